ghr_index_unit: RTL and testbench

GHR_INDEX_UNIT -- requirements
Module: ghr_index_unit

---
 rtl/ghr_index_unit_pkg.sv | 6 +
 rtl/ghr_index_unit_if.sv | 30 +++
 rtl/bp_ckpt_fifo.sv | 51 +++++
 rtl/ghr_index_unit.sv | 84 ++++++++
 tb/tb_ghr_index_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ghr_index_unit_pkg.sv
// Shared branch-predictor constants used by the GHR index unit and the PHT.
package ghr_index_unit_pkg;
  localparam int BP_D_WIDTH = 8;  // PHT index / global history width
  localparam int BP_DEPTH   = 4;  // in-flight branch checkpoints
  localparam int BP_PC_LSB  = 2;  // PC bits below this are always zero for aligned instructions
endpackage

// File: rtl/ghr_index_unit_if.sv
// Fetch/resolve signal bundle between the pipeline (master) and the GHR index unit (slave).
interface ghr_index_unit_if import ghr_index_unit_pkg::*; #(
  parameter int D_WIDTH = BP_D_WIDTH
);
  logic [31:0]        i_fetch_pc;
  logic               i_fetch_branch;
  logic               i_pred_taken;
  logic [D_WIDTH-1:0] o_pht_addr;
  logic               o_full;
  logic               i_resolve_valid;
  logic               i_actual_taken;
  logic               i_mispredict;
  logic               i_flush;
  logic               o_update;
  logic [D_WIDTH-1:0] o_update_addr;
  logic               o_update_taken;
  logic               o_underflow;

  modport master (
    output i_fetch_pc, i_fetch_branch, i_pred_taken,
    output i_resolve_valid, i_actual_taken, i_mispredict, i_flush,
    input  o_pht_addr, o_full, o_update, o_update_addr, o_update_taken, o_underflow
  );

  modport slave (
    input  i_fetch_pc, i_fetch_branch, i_pred_taken,
    input  i_resolve_valid, i_actual_taken, i_mispredict, i_flush,
    output o_pht_addr, o_full, o_update, o_update_addr, o_update_taken, o_underflow
  );
endinterface

// File: rtl/bp_ckpt_fifo.sv
// In-flight branch checkpoint FIFO: head is visible combinationally, flush empties it in one cycle.
module bp_ckpt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;

  assign w_wr    = i_push & (r_count != CW'(DEPTH));
  assign w_rd    = i_pop & (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ghr_index_unit.sv
// Gshare index generation with speculative/architectural global history and checkpoint-based repair.
module ghr_index_unit import ghr_index_unit_pkg::*; #(
  parameter int D_WIDTH = BP_D_WIDTH,
  parameter int DEPTH   = BP_DEPTH
) (
  input logic             clk,
  input logic             rst_n,
  ghr_index_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [D_WIDTH-1:0] idx;
    logic [D_WIDTH-1:0] ghr;
  } ckpt_t;

  logic [D_WIDTH-1:0] r_spec_ghr, r_arch_ghr, w_spec_nxt, w_arch_nxt, w_pht_addr;
  logic [D_WIDTH-1:0] r_update_addr;
  logic               r_update, r_update_taken, r_underflow;
  ckpt_t              w_push_ckpt, w_head;
  logic [CW-1:0]      w_count;
  logic               w_full, w_empty, w_push, w_pop, w_mp, w_clear;
  logic               w_unused;

  assign w_pht_addr  = bus.i_fetch_pc[BP_PC_LSB +: D_WIDTH] ^ r_spec_ghr;
  assign w_full      = (w_count == CW'(DEPTH));
  assign w_empty     = (w_count == '0);
  assign w_pop       = bus.i_resolve_valid & ~w_empty;
  assign w_mp        = w_pop & bus.i_mispredict;
  assign w_clear     = w_mp | bus.i_flush;
  // A push is dropped when full even if the head pops this cycle.
  assign w_push      = bus.i_fetch_branch & ~w_full & ~w_clear;
  assign w_push_ckpt = '{idx: w_pht_addr, ghr: r_spec_ghr};
  assign w_unused    = ^{bus.i_fetch_pc[31:BP_PC_LSB+D_WIDTH], bus.i_fetch_pc[BP_PC_LSB-1:0],
                         w_head.ghr[D_WIDTH-1]};

  bp_ckpt_fifo #(.WIDTH(2*D_WIDTH), .DEPTH(DEPTH)) u_ckpt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_clear),
    .i_wdata (w_push_ckpt),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_arch_nxt = r_arch_ghr;
    if (w_pop) w_arch_nxt = {r_arch_ghr[D_WIDTH-2:0], bus.i_actual_taken};
    w_spec_nxt = r_spec_ghr;
    // Mispredict repair rebuilds history from the checkpoint; a plain flush falls back to arch.
    if (w_mp)               w_spec_nxt = {w_head.ghr[D_WIDTH-2:0], bus.i_actual_taken};
    else if (bus.i_flush)   w_spec_nxt = w_arch_nxt;
    else if (w_push)        w_spec_nxt = {r_spec_ghr[D_WIDTH-2:0], bus.i_pred_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_ghr     <= '0;
      r_arch_ghr     <= '0;
      r_update       <= 1'b0;
      r_update_addr  <= '0;
      r_update_taken <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_spec_ghr <= w_spec_nxt;
      r_arch_ghr <= w_arch_nxt;
      r_update   <= w_pop;
      if (w_pop) begin
        r_update_addr  <= w_head.idx;
        r_update_taken <= bus.i_actual_taken;
      end
      if (bus.i_resolve_valid && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.o_pht_addr     = w_pht_addr;
  assign bus.o_full         = w_full;
  assign bus.o_update       = r_update;
  assign bus.o_update_addr  = r_update_addr;
  assign bus.o_update_taken = r_update_taken;
  assign bus.o_underflow    = r_underflow;
endmodule

// File: tb/tb_ghr_index_unit.sv
// Randomized check of ghr_index_unit against a queue-based history model, plus hand-computed scenarios.
module tb_ghr_index_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  ghr_index_unit_if #(.D_WIDTH(8)) bus ();
  ghr_index_unit #(.D_WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] ghr;
  } ck_t;

  ck_t        q[$];
  logic [7:0] m_spec, m_arch, m_uaddr;
  logic       m_upd, m_utaken, m_uf;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_spec = '0; m_arch = '0; m_uaddr = '0;
    m_upd = 1'b0; m_utaken = 1'b0; m_uf = 1'b0;
  endfunction

  // One clock of the architectural rules, evaluated on the inputs present at the edge.
  function automatic void model_step();
    ck_t        h;
    logic [7:0] idx, arch_n;
    bit         pop, push_ok;
    idx     = bus.i_fetch_pc[9:2] ^ m_spec;
    pop     = bus.i_resolve_valid && q.size() > 0;
    push_ok = bus.i_fetch_branch && q.size() < 4;
    if (bus.i_resolve_valid && q.size() == 0) m_uf = 1'b1;
    arch_n = pop ? {m_arch[6:0], bus.i_actual_taken} : m_arch;
    m_upd  = pop;
    h      = '{8'h0, 8'h0};
    if (pop) begin
      h        = q.pop_front();
      m_uaddr  = h.idx;
      m_utaken = bus.i_actual_taken;
    end
    if (pop && bus.i_mispredict) begin
      m_spec = {h.ghr[6:0], bus.i_actual_taken};
      q.delete();
    end else if (bus.i_flush) begin
      m_spec = arch_n;
      q.delete();
    end else if (push_ok) begin
      q.push_back('{idx, m_spec});
      m_spec = {m_spec[6:0], bus.i_pred_taken};
    end
    m_arch = arch_n;
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("pht_addr", 32'(bus.o_pht_addr), 32'(bus.i_fetch_pc[9:2] ^ m_spec));
      chk("full", 32'(bus.o_full), 32'(q.size() == 4));
      chk("update", 32'(bus.o_update), 32'(m_upd));
      chk("update_addr", 32'(bus.o_update_addr), 32'(m_uaddr));
      chk("update_taken", 32'(bus.o_update_taken), 32'(m_utaken));
      chk("underflow", 32'(bus.o_underflow), 32'(m_uf));
    end
  end

  task automatic drive(bit fb, bit pr, bit rv, bit at, bit mp, bit fl, logic [31:0] pc);
    bus.i_fetch_branch  = fb;
    bus.i_pred_taken    = pr;
    bus.i_resolve_valid = rv;
    bus.i_actual_taken  = at;
    bus.i_mispredict    = mp;
    bus.i_flush         = fl;
    bus.i_fetch_pc      = pc;
  endtask

  task automatic cyc(bit fb, bit pr, bit rv, bit at, bit mp, bit fl, logic [31:0] pc);
    drive(fb, pr, rv, at, mp, fl, pc);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(logic [31:0] pc);
    drive(0, 0, 0, 0, 0, 0, pc);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    rst_n = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    model_reset();
    #12;
    chk("rst_pht_addr", 32'(bus.o_pht_addr), 32'h10);
    chk("rst_full", 32'(bus.o_full), 32'h0);
    chk("rst_update", 32'(bus.o_update), 32'h0);
    chk("rst_underflow", 32'(bus.o_underflow), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;

    // History: T,T,N then full / drop behaviour
    cyc(1, 1, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    idle(32'h40);
    chk("hist_pht_addr", 32'(bus.o_pht_addr), 32'h16);
    cyc(1, 0, 0, 0, 0, 0, 32'h40);
    idle(32'h40);
    chk("full_set", 32'(bus.o_full), 32'h1);
    chk("full_pht_addr", 32'(bus.o_pht_addr), 32'h1c);
    cyc(1, 1, 0, 0, 0, 0, 32'h40);
    idle(32'h40);
    chk("drop_pht_addr", 32'(bus.o_pht_addr), 32'h1c);
    chk("drop_full", 32'(bus.o_full), 32'h1);
    cyc(1, 1, 1, 1, 0, 0, 32'h40);
    idle(32'h40);
    chk("droppop_pht_addr", 32'(bus.o_pht_addr), 32'h1c);
    chk("droppop_full", 32'(bus.o_full), 32'h0);
    chk("droppop_update", 32'(bus.o_update), 32'h1);
    chk("droppop_addr", 32'(bus.o_update_addr), 32'h00);

    // Mispredict repair
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 32'h40);
    cyc(1, 1, 0, 0, 0, 0, 32'h44);
    cyc(0, 0, 1, 0, 1, 0, 32'h40);
    idle(32'h40);
    chk("mp_update", 32'(bus.o_update), 32'h1);
    chk("mp_addr", 32'(bus.o_update_addr), 32'h10);
    chk("mp_taken", 32'(bus.o_update_taken), 32'h0);
    chk("mp_pht_addr", 32'(bus.o_pht_addr), 32'h10);
    chk("mp_full", 32'(bus.o_full), 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h40);
    idle(32'h40);
    chk("mp_arch", 32'(bus.o_pht_addr), 32'h10);

    // Push and correct resolve in the same cycle
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 32'h48);
    cyc(1, 1, 1, 1, 0, 0, 32'h4c);
    idle(32'h40);
    chk("conc_update", 32'(bus.o_update), 32'h1);
    chk("conc_addr", 32'(bus.o_update_addr), 32'h10);
    chk("conc_taken", 32'(bus.o_update_taken), 32'h1);
    chk("conc_pht_addr", 32'(bus.o_pht_addr), 32'h15);
    cyc(1, 0, 0, 0, 0, 0, 32'h40);
    idle(32'h40);
    chk("conc_cnt3", 32'(bus.o_full), 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h40);
    idle(32'h40);
    chk("conc_cnt4", 32'(bus.o_full), 32'h1);

    // Flush restores arch history, then resolve on empty FIFO
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 32'h40);
    cyc(0, 0, 1, 1, 0, 0, 32'h40);
    cyc(1, 1, 0, 0, 0, 0, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 32'h44);
    cyc(1, 1, 0, 0, 0, 0, 32'h48);
    cyc(1, 1, 0, 0, 0, 1, 32'h40);
    idle(32'h40);
    chk("flush_pht_addr", 32'(bus.o_pht_addr), 32'h11);
    chk("flush_full", 32'(bus.o_full), 32'h0);
    cyc(0, 0, 1, 1, 0, 0, 32'h40);
    idle(32'h40);
    chk("uf_update", 32'(bus.o_update), 32'h0);
    chk("uf_flag", 32'(bus.o_underflow), 32'h1);
    chk("uf_pht_addr", 32'(bus.o_pht_addr), 32'h11);

    // Randomized traffic with occasional mid-operation reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit rv, mp;
      logic [31:0] pc;
      rv = 1'($urandom_range(0, 4) < 2);
      mp = rv && ($urandom_range(0, 4) == 0);
      pc = $urandom;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)),
          mp, 1'($urandom_range(0, 19) == 0), pc);
      if (i % 700 == 699) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_full", 32'(bus.o_full), 32'h0);
        chk("mid_rst_pht_addr", 32'(bus.o_pht_addr), 32'(pc[9:2]));
        chk("mid_rst_update", 32'(bus.o_update), 32'h0);
        chk("mid_rst_underflow", 32'(bus.o_underflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
